// File: rtl/star_pkg.sv
// Shared types and default constants for the star power-up block.
package star_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POWER = 2'd1,
    BLINK = 2'd2
  } star_state_e;

  localparam int NUM_STARS    = 4;
  localparam int POWER_FRAMES = 600;
  localparam int BLINK_FRAMES = 120;
  localparam int MAX_COUNT    = 99;

  // Packs {tens, ones} for a 0..99 binary value.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens   = 4'(v / 7'd10);
    ones   = 4'(v % 7'd10);
    to_bcd = {tens, ones};
  endfunction

endpackage

// File: rtl/star_power_bcd_sat_counter.sv
// Saturating star counter that registers binary and BCD forms together,
// so the HUD digits never lag the binary count.
module bcd_sat_counter
  import star_pkg::*;
#(
  parameter int MAX_COUNT = star_pkg::MAX_COUNT
) (
  input  logic       sys_clk,
  input  logic       RST,
  input  logic       hold,
  input  logic [7:0] hits,
  output logic [6:0] count,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] count_q, count_d;
  logic [7:0] bcd_q, bcd_d;
  logic [7:0] sum;

  always_comb begin
    sum     = {1'b0, count_q} + hits;
    count_d = count_q;
    if (!hold) begin
      if (sum > 8'(MAX_COUNT)) count_d = 7'(MAX_COUNT);
      else                     count_d = sum[6:0];
    end
    bcd_d = to_bcd(count_d);
  end

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      count_q <= '0;
      bcd_q   <= '0;
    end else begin
      count_q <= count_d;
      bcd_q   <= bcd_d;
    end
  end

  assign count = count_q;
  assign tens  = bcd_q[7:4];
  assign ones  = bcd_q[3:0];

endmodule

// File: rtl/star_power.sv
// Star pickup counter plus invincibility timer with a blinking warning phase.
module star_power
  import star_pkg::*;
#(
  parameter int NUM_STARS    = star_pkg::NUM_STARS,
  parameter int POWER_FRAMES = star_pkg::POWER_FRAMES,
  parameter int BLINK_FRAMES = star_pkg::BLINK_FRAMES,
  parameter int MAX_COUNT    = star_pkg::MAX_COUNT
) (
  input  logic                 sys_clk,
  input  logic                 RST,
  input  logic                 frame_tick,
  input  logic [NUM_STARS-1:0] touch_star,
  input  logic                 game_over,
  output logic [6:0]           star_count,
  output logic [3:0]           star_tens,
  output logic [3:0]           star_ones,
  output logic                 invincible,
  output logic                 char_visible,
  output logic                 power_start,
  output star_state_e          dbg_state,
  output logic [9:0]           dbg_frames_left
);

  star_state_e state_q, state_d;
  logic [9:0]  frames_left_q, frames_left_d;
  logic [9:0]  frames_dec;
  logic [7:0]  hits;
  logic        reload;
  logic        invincible_q, invincible_d;
  logic        char_visible_q, char_visible_d;
  logic        power_start_q, power_start_d;

  // game_over masks collisions entirely, so it also blocks reloads.
  always_comb begin
    hits = '0;
    if (!game_over) begin
      for (int i = 0; i < NUM_STARS; i++) hits = hits + 8'(touch_star[i]);
    end
  end

  assign reload     = (hits != 8'd0);
  assign frames_dec = frames_left_q - 10'd1;

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      state_q        <= IDLE;
      frames_left_q  <= '0;
      invincible_q   <= 1'b0;
      char_visible_q <= 1'b1;
      power_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      frames_left_q  <= frames_left_d;
      invincible_q   <= invincible_d;
      char_visible_q <= char_visible_d;
      power_start_q  <= power_start_d;
    end
  end

  // Reload takes precedence over a same-cycle frame tick.
  always_comb begin
    state_d       = state_q;
    frames_left_d = frames_left_q;
    if (game_over) begin
      state_d       = IDLE;
      frames_left_d = '0;
    end else if (reload) begin
      state_d       = POWER;
      frames_left_d = 10'(POWER_FRAMES);
    end else begin
      case (state_q)
        POWER: if (frame_tick) begin
          frames_left_d = frames_dec;
          if (frames_dec == 10'(BLINK_FRAMES)) state_d = BLINK;
        end
        BLINK: if (frame_tick) begin
          frames_left_d = frames_dec;
          if (frames_dec == 10'd0) state_d = IDLE;
        end
        default: begin
          state_d       = IDLE;
          frames_left_d = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they land in the same edge.
  always_comb begin
    invincible_d   = (state_d != IDLE);
    char_visible_d = (state_d == BLINK) ? frames_left_d[3] : 1'b1;
    power_start_d  = reload;
  end

  bcd_sat_counter #(
    .MAX_COUNT(MAX_COUNT)
  ) u_counter (
    .sys_clk(sys_clk),
    .RST    (RST),
    .hold   (game_over),
    .hits   (hits),
    .count  (star_count),
    .tens   (star_tens),
    .ones   (star_ones)
  );

  assign invincible      = invincible_q;
  assign char_visible    = char_visible_q;
  assign power_start     = power_start_q;
  assign dbg_state       = state_q;
  assign dbg_frames_left = frames_left_q;

endmodule

// File: tb/tb_star_power.sv
// Directed bench for star_power with short frame counts (20 / 8).
module tb_star_power;
  import star_pkg::*;

  logic        sys_clk = 1'b0;
  logic        RST = 1'b1;
  logic        frame_tick = 1'b0;
  logic [3:0]  touch_star = 4'b0000;
  logic        game_over = 1'b0;
  logic [6:0]  star_count;
  logic [3:0]  star_tens;
  logic [3:0]  star_ones;
  logic        invincible;
  logic        char_visible;
  logic        power_start;
  star_state_e dbg_state;
  logic [9:0]  dbg_frames_left;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sys_clk = ~sys_clk;

  star_power #(
    .NUM_STARS   (4),
    .POWER_FRAMES(20),
    .BLINK_FRAMES(8),
    .MAX_COUNT   (99)
  ) dut (
    .sys_clk        (sys_clk),
    .RST            (RST),
    .frame_tick     (frame_tick),
    .touch_star     (touch_star),
    .game_over      (game_over),
    .star_count     (star_count),
    .star_tens      (star_tens),
    .star_ones      (star_ones),
    .invincible     (invincible),
    .char_visible   (char_visible),
    .power_start    (power_start),
    .dbg_state      (dbg_state),
    .dbg_frames_left(dbg_frames_left)
  );

  // One clock: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic [3:0] t, input logic tick, input logic go, input logic rst);
    @(negedge sys_clk);
    touch_star = t;
    frame_tick = tick;
    game_over  = go;
    RST        = rst;
    @(posedge sys_clk);
    #1;
    touch_star = 4'b0000;
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input int cnt, input int st, input int fl,
                         input logic inv, input logic vis, input logic ps);
    chk({tag, " count"}, 32'(star_count), 32'(cnt));
    chk({tag, " tens"}, 32'(star_tens), 32'(cnt / 10));
    chk({tag, " ones"}, 32'(star_ones), 32'(cnt % 10));
    chk({tag, " state"}, 32'(dbg_state), 32'(st));
    chk({tag, " frames"}, 32'(dbg_frames_left), 32'(fl));
    chk({tag, " invincible"}, 32'(invincible), 32'(inv));
    chk({tag, " visible"}, 32'(char_visible), 32'(vis));
    chk({tag, " power_start"}, 32'(power_start), 32'(ps));
  endtask

  initial begin
    // Reset
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk_out("reset", 0, 0, 0, 1'b0, 1'b1, 1'b0);

    // Three simultaneous touches count individually and start power
    step(4'b1011, 1'b0, 1'b0, 1'b0);
    chk_out("touch3", 3, 1, 20, 1'b1, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk_out("power_hold", 3, 1, 20, 1'b1, 1'b1, 1'b0);

    // 11 ticks stay in POWER, the 12th enters BLINK at 8
    for (int k = 1; k <= 11; k++) step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk_out("tick11", 3, 1, 9, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk_out("tick12_blink", 3, 2, 8, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk_out("blink5", 3, 2, 5, 1'b1, 1'b0, 1'b0);

    // Touch and tick together at frames_left=5: reload wins
    step(4'b0001, 1'b1, 1'b0, 1'b0);
    chk_out("reload_tick", 4, 1, 20, 1'b1, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk_out("reload_after", 4, 1, 20, 1'b1, 1'b1, 1'b0);

    // game_over in POWER with touches: IDLE, count frozen
    step(4'b1111, 1'b0, 1'b1, 1'b0);
    chk_out("gameover", 4, 0, 0, 1'b0, 1'b1, 1'b0);
    step(4'b0110, 1'b1, 1'b1, 1'b0);
    chk_out("gameover_hold", 4, 0, 0, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk_out("gameover_release", 4, 0, 0, 1'b0, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk_out("resume_touch", 5, 1, 20, 1'b1, 1'b1, 1'b1);

    // Full countdown: 12 ticks to BLINK, 8 ticks to IDLE with blink pattern
    for (int k = 1; k <= 12; k++) step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk_out("blink_entry", 5, 2, 8, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(4'b0000, 1'b1, 1'b0, 1'b0);
      chk("blink_frames", 32'(dbg_frames_left), 32'(8 - k));
      chk("blink_visible", 32'(char_visible), 32'd0);
      chk("blink_inv", 32'(invincible), 32'd1);
    end
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk_out("expire", 5, 0, 0, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk_out("idle_tick", 5, 0, 0, 1'b0, 1'b1, 1'b0);

    // Climb to 97 (5 + 23*4 = 97), then saturate at 99
    for (int k = 1; k <= 23; k++) step(4'b1111, 1'b0, 1'b0, 1'b0);
    chk_out("count97", 97, 1, 20, 1'b1, 1'b1, 1'b1);
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    chk_out("sat99", 99, 1, 20, 1'b1, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0, 1'b0);
    chk_out("sat_hold", 99, 1, 20, 1'b1, 1'b1, 1'b1);

    // Reset mid-POWER overrides touch, tick and game_over
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk_out("pre_reset", 99, 1, 19, 1'b1, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0, 1'b1);
    chk_out("mid_reset", 0, 0, 0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/star_power.md
STAR_POWER -- requirements
Module: star_power

Interface
REQ-001 SHALL have parameter NUM_STARS, default 4: number of star collision sources.
REQ-002 SHALL have parameter POWER_FRAMES, default 600: invincibility duration in frames.
REQ-003 SHALL have parameter BLINK_FRAMES, default 120: warning-phase length in frames; must be below POWER_FRAMES.
REQ-004 SHALL have parameter MAX_COUNT, default 99: star-count saturation value.
REQ-005 sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 touch_star  in  NUM_STARS  one-cycle collision pulses from star blocks, one bit per star.
REQ-009 game_over  in  1  level-sensitive freeze/abort.
REQ-010 star_count  out  7  binary stars collected, saturating.
REQ-011 star_tens, star_ones  out  4 each  BCD digits of star_count, for the HUD.
REQ-012 invincible  out  1  high in POWER or BLINK.
REQ-013 char_visible  out  1  character sprite enable, for blink rendering.
REQ-014 power_start  out  1  one-cycle pulse on each invincibility (re)load, for sound.

Function
REQ-015 All outputs SHALL be registered and SHALL update on the edge after the causing input is sampled (latency 1).
REQ-016 hits SHALL be the popcount of touch_star (0..NUM_STARS) in that cycle; simultaneous touches each count.
REQ-017 star_count SHALL become min(star_count + hits, MAX_COUNT); the sum is computed at 8 bits, so there is no wrap.
REQ-018 star_tens/star_ones SHALL always equal the BCD of star_count in the same cycle; there is no intermediate mismatch.
REQ-019 The FSM SHALL have states IDLE, POWER, BLINK and a frame counter frames_left, 10 bits.
REQ-020 With hits>0 in any state, the FSM SHALL go to POWER, set frames_left=POWER_FRAMES and pulse power_start.
REQ-021 In POWER on frame_tick, frames_left SHALL decrement; the FSM SHALL enter BLINK when the new value equals BLINK_FRAMES.
REQ-022 In BLINK on frame_tick, frames_left SHALL decrement; the FSM SHALL enter IDLE when the new value equals 0.
REQ-023 When hits>0 and frame_tick occur in the same cycle, the reload SHALL win and no decrement SHALL apply.
REQ-024 frame_tick in IDLE SHALL be ignored; frames_left SHALL hold at 0.
REQ-025 char_visible SHALL be 1 in IDLE and POWER, and SHALL equal frames_left[3] in BLINK, toggling every 8 frames.
REQ-026 While game_over=1, the block SHALL force IDLE, frames_left=0 and power_start=0, and ignore touch_star; star_count SHALL hold.
REQ-027 When game_over deasserts, the block SHALL resume from IDLE with the held count.

Reset
REQ-028 On RST=1 at a clock edge, the block SHALL set: state IDLE, frames_left 0, star_count 0, star_tens 0, star_ones 0, invincible 0, char_visible 1, power_start 0.
REQ-029 RST SHALL take priority over game_over, touch_star and frame_tick, including mid-POWER/BLINK.

Structure
REQ-030 Package star_pkg SHALL hold the state enum (IDLE, POWER, BLINK) and the default constants POWER_FRAMES, BLINK_FRAMES, MAX_COUNT, NUM_STARS.
REQ-031 There SHALL be one sub-module, bcd_sat_counter: saturating binary+BCD counter with increment input hits, sys_clk, RST and hold.
REQ-032 The FSM, frame counter and popcount SHALL reside in star_power.

Verification
REQ-033 Reset check: assert RST for 2 cycles mid-POWER -> next cycle star_count=0, invincible=0, char_visible=1.
REQ-034 Count and saturation: touch_star=4'b1011 once -> star_count=3 (tens 0, ones 3); preload to 97 then 4'b1111 -> 99 (tens 9, ones 9), and further touches stay 99.
REQ-035 Timing, POWER_FRAMES=20, BLINK_FRAMES=8: touch, then 12 ticks -> BLINK entered on 12th tick; 8 more ticks -> IDLE, invincible=0.
REQ-036 Reload priority: touch and frame_tick in the same cycle while frames_left=5 in BLINK -> POWER, frames_left=20, power_start high for exactly 1 cycle.
REQ-037 Blink pattern, BLINK phase: char_visible follows frames_left[3] (frames_left 8..1 -> 1,0,0,0,0,0,0,0).
REQ-038 game_over: raise game_over during POWER with touches applied -> IDLE next cycle, count frozen; deassert, then touch -> count+1, POWER.
